// File: rtl/regfile_wr_arbiter_pkg.sv
// rtl/regfile_wr_arbiter_pkg.sv - shared state type, default sizes and pick helper for the write-port controller
package regfile_ctrl_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH  = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } ctrl_state_e;

  // One-hot pick between two requesters; on contention the one not served last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last);
    logic [1:0] g;
    g = 2'b00;
    case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - requester handshakes and register-file write port bundle
interface regfile_wr_arbiter_if
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_adr;
  logic [DATA_W-1:0] req0_data;

  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_adr;
  logic [DATA_W-1:0] req1_data;

  logic [ADDR_W-1:0] W_ADR;
  logic [DATA_W-1:0] D;
  logic              W_en;

  modport master (
    output req0_valid, req0_adr, req0_data,
    output req1_valid, req1_adr, req1_data,
    input  req0_ready, req1_ready,
    input  W_ADR, D, W_en
  );

  modport slave (
    input  req0_valid, req0_adr, req0_data,
    input  req1_valid, req1_adr, req1_data,
    output req0_ready, req1_ready,
    output W_ADR, D, W_en
  );

endinterface

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// rtl/regfile_wr_arbiter_rr_arb2.sv - two-way round-robin arbiter owning the last-grant history
module rr_arb2
  import regfile_ctrl_pkg::*;
(
  input  logic       UserCLK,
  input  logic       resetn,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant_q;

  assign grant = rr_pick(valid, last_grant_q);

  // History only moves on an actual transfer so a stalled grant keeps its priority.
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      last_grant_q <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_grant_q <= grant[1];
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - shares the register-file write port between two requesters and sequences array clears
module regfile_wr_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DEPTH          = DEF_DEPTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 UserCLK,
  input  logic                 resetn,
  input  logic                 clr_req,
  output logic                 clr_busy,
  regfile_wr_arbiter_if.slave  bus
);

  localparam ctrl_state_e      RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
  localparam logic [ADDR_W-1:0] CNT_LAST   = ADDR_W'(DEPTH - 1);

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              w_en_q, w_en_d;
  logic [ADDR_W-1:0] w_adr_q, w_adr_d;
  logic [DATA_W-1:0] d_q, d_d;

  logic              arb_en;
  logic [1:0]        arb_valid;
  logic [1:0]        grant;

  // A clear request suppresses arbitration in the same cycle it is seen.
  assign arb_en    = (state_q == ST_ARB) && !clr_req;
  assign arb_valid = arb_en ? {bus.req1_valid, bus.req0_valid} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .UserCLK (UserCLK),
    .resetn  (resetn),
    .valid   (arb_valid),
    .advance (grant != 2'b00),
    .grant   (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign clr_busy       = (state_q == ST_CLEAR);

  assign bus.W_en  = w_en_q;
  assign bus.W_ADR = w_adr_q;
  assign bus.D     = d_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    w_en_d    = 1'b0;
    w_adr_d   = w_adr_q;
    d_d       = d_q;

    case (state_q)
      ST_CLEAR: begin
        w_en_d  = 1'b1;
        w_adr_d = clr_cnt_q;
        d_d     = '0;
        if (clr_cnt_q == CNT_LAST) begin
          state_d   = ST_ARB;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end

      ST_ARB: begin
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else if (grant[0]) begin
          w_en_d  = 1'b1;
          w_adr_d = bus.req0_adr;
          d_d     = bus.req0_data;
        end else if (grant[1]) begin
          w_en_d  = 1'b1;
          w_adr_d = bus.req1_adr;
          d_d     = bus.req1_data;
        end
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
      w_en_q    <= 1'b0;
      w_adr_q   <= '0;
      d_q       <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      w_en_q    <= w_en_d;
      w_adr_q   <= w_adr_d;
      d_q       <= d_d;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed and random checks of regfile_wr_arbiter against a behavioural model
module tb_regfile_wr_arbiter;
  import regfile_ctrl_pkg::*;

  localparam int DW   = 4;
  localparam int AW   = 5;
  localparam int NDEP = 32;

  logic UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  logic resetn_a, clr_req_a, clr_busy_a;
  logic resetn_b, clr_req_b, clr_busy_b;

  regfile_wr_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
  regfile_wr_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

  regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(NDEP), .CLEAR_ON_RESET(1'b1)) dut_a (
    .UserCLK (UserCLK), .resetn (resetn_a), .clr_req (clr_req_a),
    .clr_busy (clr_busy_a), .bus (bus_a)
  );

  regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(NDEP), .CLEAR_ON_RESET(1'b0)) dut_b (
    .UserCLK (UserCLK), .resetn (resetn_b), .clr_req (clr_req_b),
    .clr_busy (clr_busy_b), .bus (bus_b)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: is a sweep running, which entry is next, who was served last.
  bit          m_sweep;
  int          m_idx;
  int          m_last;
  logic        m_wen;
  logic [AW-1:0] m_wadr;
  logic [DW-1:0] m_d;

  bit acc0, acc1;
  int wr_adr_log[$];
  int wr_dat_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sweep = 1'b1;
    m_idx   = 0;
    m_last  = 1;
    m_wen   = 1'b0;
    m_wadr  = '0;
    m_d     = '0;
  endtask

  function automatic int pick();
    if (m_sweep || clr_req_a) return -1;
    if (bus_a.req0_valid && bus_a.req1_valid) return 1 - m_last;
    if (bus_a.req0_valid) return 0;
    if (bus_a.req1_valid) return 1;
    return -1;
  endfunction

  // One clock of dut_a: check readies, advance the model at the edge, then check the write port.
  task automatic cyc_a();
    int g;
    #1;
    g = pick();
    chk("ready0", bus_a.req0_ready, (g == 0));
    chk("ready1", bus_a.req1_ready, (g == 1));
    chk("clr_busy", clr_busy_a, m_sweep);
    @(posedge UserCLK);
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!resetn_a) begin
      model_reset();
    end else if (m_sweep) begin
      m_wen  = 1'b1;
      m_wadr = AW'(m_idx);
      m_d    = '0;
      if (m_idx == NDEP - 1) begin
        m_sweep = 1'b0;
        m_idx   = 0;
      end else begin
        m_idx++;
      end
    end else if (clr_req_a) begin
      m_wen   = 1'b0;
      m_sweep = 1'b1;
      m_idx   = 0;
    end else if (g == 0) begin
      m_wen = 1'b1; m_wadr = bus_a.req0_adr; m_d = bus_a.req0_data; m_last = 0; acc0 = 1'b1;
    end else if (g == 1) begin
      m_wen = 1'b1; m_wadr = bus_a.req1_adr; m_d = bus_a.req1_data; m_last = 1; acc1 = 1'b1;
    end else begin
      m_wen = 1'b0;
    end
    #1;
    chk("W_en", bus_a.W_en, m_wen);
    chk("W_ADR", bus_a.W_ADR, m_wadr);
    chk("D", bus_a.D, m_d);
    if (bus_a.W_en === 1'b1) begin
      wr_adr_log.push_back(int'(bus_a.W_ADR));
      wr_dat_log.push_back(int'(bus_a.D));
    end
    @(negedge UserCLK);
  endtask

  function automatic int sweep_bad_index();
    if (wr_adr_log.size() != NDEP) return 999;
    for (int i = 0; i < NDEP; i++)
      if (wr_adr_log[i] != i || wr_dat_log[i] != 0) return i;
    return -1;
  endfunction

  initial begin
    int n;
    resetn_a = 1'b0; clr_req_a = 1'b0;
    resetn_b = 1'b0; clr_req_b = 1'b0;
    bus_a.req0_valid = 1'b0; bus_a.req0_adr = '0; bus_a.req0_data = '0;
    bus_a.req1_valid = 1'b0; bus_a.req1_adr = '0; bus_a.req1_data = '0;
    bus_b.req0_valid = 1'b0; bus_b.req0_adr = '0; bus_b.req0_data = '0;
    bus_b.req1_valid = 1'b0; bus_b.req1_adr = '0; bus_b.req1_data = '0;
    model_reset();
    repeat (2) @(negedge UserCLK);

    // Reset values
    chk("rst_W_en", bus_a.W_en, 1'b0);
    chk("rst_W_ADR", bus_a.W_ADR, '0);
    chk("rst_D", bus_a.D, '0);
    chk("rst_busy_a", clr_busy_a, 1'b1);
    chk("rst_busy_b", clr_busy_b, 1'b0);

    // Sweep after reset with both requesters already waiting
    resetn_a = 1'b1;
    bus_a.req0_valid = 1'b1; bus_a.req0_adr = 5'd1; bus_a.req0_data = 4'h3;
    bus_a.req1_valid = 1'b1; bus_a.req1_adr = 5'd2; bus_a.req1_data = 4'hC;
    wr_adr_log.delete(); wr_dat_log.delete();
    repeat (NDEP) cyc_a();
    chk("t1_sweep_order", sweep_bad_index(), -1);
    chk("t1_busy_low", clr_busy_a, 1'b0);

    // Continuous contention alternates 0,1,0,1
    wr_adr_log.delete(); wr_dat_log.delete();
    repeat (4) cyc_a();
    chk("t3_count", wr_adr_log.size(), 4);
    chk("t3_adr_seq", {wr_adr_log[0][3:0], wr_adr_log[1][3:0], wr_adr_log[2][3:0], wr_adr_log[3][3:0]}, 16'h1212);
    chk("t3_dat_seq", {wr_dat_log[0][3:0], wr_dat_log[1][3:0], wr_dat_log[2][3:0], wr_dat_log[3][3:0]}, 16'h3C3C);

    // Single requester
    bus_a.req1_valid = 1'b0;
    bus_a.req0_adr = 5'd5; bus_a.req0_data = 4'hA;
    #1 chk("t2_ready0", bus_a.req0_ready, 1'b1);
    cyc_a();
    chk("t2_W", {bus_a.W_en, bus_a.W_ADR, bus_a.D}, {1'b1, 5'd5, 4'hA});
    bus_a.req0_valid = 1'b0;
    cyc_a();
    chk("t2_idle", {bus_a.W_en, bus_a.W_ADR}, {1'b0, 5'd5});

    // Clear request against a waiting requester, with a mid-sweep re-request
    clr_req_a = 1'b1;
    bus_a.req1_valid = 1'b1; bus_a.req1_adr = 5'd7; bus_a.req1_data = 4'h6;
    #1 chk("t4_ready1_blocked", bus_a.req1_ready, 1'b0);
    cyc_a();
    clr_req_a = 1'b0;
    wr_adr_log.delete(); wr_dat_log.delete();
    for (int i = 0; i < NDEP; i++) begin
      clr_req_a = (i == 10);
      cyc_a();
    end
    clr_req_a = 1'b0;
    chk("t4_sweep_order", sweep_bad_index(), -1);
    chk("t4_busy_low", clr_busy_a, 1'b0);
    cyc_a();
    chk("t4_req1_after", {bus_a.W_en, bus_a.W_ADR, bus_a.D}, {1'b1, 5'd7, 4'h6});
    bus_a.req1_valid = 1'b0;

    // Reset in the middle of a sweep
    clr_req_a = 1'b1;
    cyc_a();
    clr_req_a = 1'b0;
    n = 0;
    while (!(bus_a.W_en === 1'b1 && bus_a.W_ADR === 5'd10) && n < 40) begin
      cyc_a();
      n++;
    end
    chk("t5_reach_adr10", (n < 40), 1'b1);
    resetn_a = 1'b0;
    cyc_a();
    chk("t5_dropped", bus_a.W_en, 1'b0);
    resetn_a = 1'b1;
    wr_adr_log.delete(); wr_dat_log.delete();
    repeat (NDEP) cyc_a();
    chk("t5_restart_order", sweep_bad_index(), -1);

    // Instance without clear-on-reset accepts a write in cycle 0
    resetn_b = 1'b1;
    bus_b.req0_valid = 1'b1; bus_b.req0_adr = 5'd9; bus_b.req0_data = 4'h5;
    #1;
    chk("t6_busy", clr_busy_b, 1'b0);
    chk("t6_ready0", bus_b.req0_ready, 1'b1);
    @(posedge UserCLK);
    #1 chk("t6_W", {bus_b.W_en, bus_b.W_ADR, bus_b.D}, {1'b1, 5'd9, 4'h5});
    @(negedge UserCLK);
    bus_b.req0_valid = 1'b0;

    // Random traffic, requesters keep their payload until accepted
    acc0 = 1'b1; acc1 = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (!bus_a.req0_valid || acc0) begin
        bus_a.req0_valid = ($urandom_range(0, 1) == 1);
        bus_a.req0_adr   = AW'($urandom_range(0, 31));
        bus_a.req0_data  = DW'($urandom_range(0, 15));
      end
      if (!bus_a.req1_valid || acc1) begin
        bus_a.req1_valid = ($urandom_range(0, 1) == 1);
        bus_a.req1_adr   = AW'($urandom_range(0, 31));
        bus_a.req1_data  = DW'($urandom_range(0, 15));
      end
      clr_req_a = ($urandom_range(0, 39) == 0);
      resetn_a  = ($urandom_range(0, 199) != 0);
      cyc_a();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
